// File: rtl/rv32m_muldiv_seq.sv
// rtl/rv32m_muldiv_seq.sv - RV32M sequential multiply/divide unit with pipeline stall
module rv32m_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic [2:0]           op_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     opnd_q;   // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q;    // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [CNT_W-1:0]     cnt_q;

  logic                 accept;
  logic                 a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 div_zero, div_ovf, special;
  logic [WIDTH-1:0]     special_res;
  logic [WIDTH:0]       mul_sum, rem_sh;
  logic                 fits;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, acc_next, prod_fix;
  logic [WIDTH-1:0]     div_sel, div_fix, calc_res;

  assign accept = (state == IDLE) && i_start && !i_flush;

  // Operand decode at accept time: signedness, magnitudes, result sign and early-out cases
  always_comb begin
    a_signed    = i_op[2] ? !i_op[0] : (i_op != 3'd3);
    b_signed    = i_op[2] ? !i_op[0] : !i_op[1];
    a_neg       = a_signed && i_rs1[WIDTH-1];
    b_neg       = b_signed && i_rs2[WIDTH-1];
    a_mag       = a_neg ? -i_rs1 : i_rs1;
    b_mag       = b_neg ? -i_rs2 : i_rs2;
    // REM/REMU take the dividend's sign; everything else the xor of the signed operands
    neg_in      = (i_op[2] && i_op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero    = i_op[2] && (i_rs2 == '0);
    div_ovf     = i_op[2] && !i_op[0] && (i_rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_rs2 == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = i_op[1] ? i_rs1 : '1;
    else if (div_ovf)
      special_res = i_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One shift-add or restoring-divide step, plus the sign fix-up and result select
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    fits     = rem_sh >= {1'b0, opnd_q};
    diff     = rem_sh[WIDTH-1:0] - opnd_q;
    div_next = {(fits ? diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], fits};
    acc_next = op_q[2] ? div_next : mul_next;
    prod_fix = neg_q ? -acc_next : acc_next;
    div_sel  = op_q[1] ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
    div_fix  = neg_q ? -div_sel : div_sel;
    case (op_q)
      3'd0:                calc_res = prod_fix[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    calc_res = prod_fix[2*WIDTH-1:WIDTH];
      default:             calc_res = div_fix;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and stall; a flush always wins and returns to IDLE
  always_comb begin
    state_next = state;
    o_stall    = i_rst_n && (accept || (state == CALC));
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (i_flush) state_next = IDLE;
  end

  // Datapath registers, iteration counter and registered result/done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        op_q   <= i_op;
        neg_q  <= neg_in;
        opnd_q <= i_op[2] ? b_mag : a_mag;
        acc_q  <= {{WIDTH{1'b0}}, (i_op[2] ? a_mag : b_mag)};
        cnt_q  <= CNT_W'(WIDTH - 1);
        if (special) begin
          o_result <= special_res;
          o_done   <= 1'b1;
        end
      end else if (state == CALC && !i_flush) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          o_result <= calc_res;
          o_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_seq.sv
// tb/tb_rv32m_muldiv_seq.sv - self-checking bench for rv32m_muldiv_seq
module tb_rv32m_muldiv_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_rs1, i_rs2;
  logic        i_flush;
  logic        o_stall, o_done;
  logic [31:0] o_result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_result = 32'd0;

  rv32m_muldiv_seq #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
    .o_stall(o_stall), .o_done(o_done), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics from 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    q  = 64'sd0;
    r  = 64'sd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; return q[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Called at the start of an IDLE cycle; returns at the start of the cycle after DONE
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res);
    int lat;
    bit got;
    lat = is_special(op, a, b) ? 1 : 33;
    got = 0;
    vectors++;
    i_start = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_flush = 1'b0;
    #1;
    check("stall_on_accept", 32'(o_stall), 32'd1);
    check("done_idle", 32'(o_done), 32'd0);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        got = 1;
        check("latency", 32'(k), 32'(lat));
        check("result", o_result, exp_res);
        check("stall_in_done", 32'(o_stall), 32'd0);
        i_start = 1'b0;
      end else begin
        check("stall_busy", 32'(o_stall), 32'd1);
        i_op  = 3'($urandom_range(0, 7));
        i_rs1 = $urandom;
        i_rs2 = $urandom;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    i_start = 1'b0;
    @(negedge i_clk);
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("result_held", o_result, exp_res);
    last_result = exp_res;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    i_rst_n = 1'b0; i_start = 1'b0; i_op = 3'd0; i_rs1 = 32'd0; i_rs2 = 32'd0; i_flush = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    do_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    do_op(3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA);
    do_op(3'd6, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE);
    do_op(3'd5, 32'd100,      32'd7,        32'd14);
    do_op(3'd7, 32'd100,      32'd7,        32'd2);
    do_op(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF);
    do_op(3'd6, 32'd5,        32'd0,        32'd5);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);

    // Flush a DIV in its tenth CALC cycle, then start MUL 3x4 in the next cycle
    vectors++;
    i_start = 1'b1; i_op = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      check("flush_pre_done", 32'(o_done), 32'd0);
    end
    i_flush = 1'b1;
    #1;
    check("flush_cycle_stall", 32'(o_stall), 32'd1);
    @(negedge i_clk);
    i_flush = 1'b0; i_start = 1'b0;
    #1;
    check("flush_idle_stall", 32'(o_stall), 32'd0);
    check("flush_no_done", 32'(o_done), 32'd0);
    check("flush_result_kept", o_result, last_result);
    do_op(3'd0, 32'd3, 32'd4, 32'd12);

    // Flush together with start in IDLE: nothing accepted
    vectors++;
    i_start = 1'b1; i_flush = 1'b1; i_op = 3'd5; i_rs1 = 32'd50; i_rs2 = 32'd5;
    #1;
    check("flush_start_stall", 32'(o_stall), 32'd0);
    @(negedge i_clk);
    i_start = 1'b0; i_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("flush_start_not_taken", {30'd0, o_stall, o_done}, 32'd0);
    end
    check("flush_start_result", o_result, last_result);

    // Asynchronous reset in cycle N+5 of a MUL
    vectors++;
    i_start = 1'b1; i_op = 3'd0; i_rs1 = 32'd12345; i_rs2 = 32'd678;
    for (int k = 1; k <= 5; k++) @(negedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    check("arst_done", 32'(o_done), 32'd0);
    check("arst_result", o_result, 32'd0);
    check("arst_stall", 32'(o_stall), 32'd0);
    i_start = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_idle", {30'd0, o_stall, o_done}, 32'd0);
    do_op(3'd5, 32'd9, 32'd2, 32'd4);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, model(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_seq.md
# rv32m_muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions in the execute stage, alongside the single-cycle integer ALU. It accepts an M-extension op from EX, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline via a stall request until the result is ready. Divide-by-zero and signed-overflow cases complete in one cycle with the RISC-V-mandated results.

## Interface

- WIDTH, 32, operand/result width; the design supports 32 only.
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_start  in  1  EX holds a valid M-op; a level held by upstream until o_done.
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1  in  WIDTH  operand A (multiplicand/dividend).
- i_rs2  in  WIDTH  operand B (multiplier/divisor).
- i_flush  in  1  kill the in-flight op (branch/trap flush).
- o_stall  out  1  combinational pipeline stall request.
- o_done  out  1  registered; one-cycle result-valid pulse.
- o_result  out  WIDTH  registered result; valid when o_done=1, held afterwards.

## Operation

- States: IDLE, CALC, DONE.
- IDLE, with i_start=1 and i_flush=0:
  - Latch i_op.
  - Latch operand magnitudes: |x| for signed operands, raw value for unsigned; MULHSU treats rs2 as unsigned.
  - Latch the result-negate flag:
    - Multiply: sign(A) xor sign(B), using signed operands only.
    - Quotient: signs differ.
    - Remainder: sign of dividend.
- IDLE special cases go straight to DONE with the result loaded:
  - Divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Otherwise IDLE -> CALC with iteration counter = 31.
- CALC performs one iteration per cycle; the counter decrements and CALC -> DONE when it equals 0 (32 iterations).
  - Multiply: 64-bit product accumulator, shift-add, LSB-first on the multiplier.
  - Divide: restoring, 33-bit trial subtract of the remainder, quotient bit shifted in at the LSB.
- CALC -> DONE entry: apply the two's-complement negate if flagged, then select:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Write the selection into o_result and set o_done=1.
- DONE -> IDLE unconditionally; o_done lasts exactly one cycle.
- o_stall = (state==IDLE & i_start & ~i_flush) | (state==CALC). o_stall=0 in DONE, so EX advances on that edge.
- i_start is ignored outside IDLE, and operand changes mid-CALC have no effect.
- i_flush has priority over everything: any state -> IDLE next edge, no o_done, o_result unchanged.
  - Asserted in IDLE with i_start: the op is not accepted and o_stall=0.
  - Asserted in DONE: o_done still pulses, because the result has already been registered.
- Reset (any time, including mid-CALC): state=IDLE, counter=0, o_done=0, o_result=0, internal accumulators cleared, o_stall=0 unless i_start is already high after reset release.

## Timing

- Op accepted on edge N (IDLE with i_start high).
- Normal op: CALC occupies cycles N+1..N+32; o_done=1 and o_result valid in cycle N+33. o_stall is high in cycles N..N+32 and low in N+33.
- Special-case op: DONE in cycle N+1; o_done and o_result valid in N+1; o_stall high only in cycle N.
- Back-to-back ops: the next op is accepted at the earliest on the edge ending cycle N+34 (first IDLE cycle after DONE). A normal-op throughput of 34 cycles per op is the requirement.
- Flush during cycle k: IDLE in k+1, with o_stall low in k+1.

## Test plan

- MUL 7 × 0xFFFFFFFD (-3), i_start at N -> o_stall high N..N+32; o_done only at N+33 with o_result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFA; REM -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU -> 2; each at N+33.
- Divide-by-zero and overflow -> results at N+1 with o_stall high only in cycle N:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- DIV started at N, i_flush in cycle N+10 -> IDLE at N+11, no o_done pulse ever, o_result keeps its previous value. A new MUL 3×4 started at N+11 -> 12 at N+44.
- i_rst_n low in cycle N+5 of a MUL -> o_done=0, o_result=0, o_stall=0 immediately (asynchronous). After release, a fresh DIVU 9/2 completes correctly with result 4.
